hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 36 +++
 rtl/hazard_unit.sv | 154 +++++++++++++++
 tb/tb_hazard_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard unit: forward selects,
// result-source encoding, FSM states, watchdog limit and the register
// match helper used by both the hazard and forwarding logic.
package hazard_unit_pkg;

    // ALU operand forward select
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_sel_e;

    // Result source of the instruction in execute; RESULT_MEM is a load
    typedef enum logic [1:0] {
        RESULT_ALU = 2'b00,
        RESULT_MEM = 2'b01,
        RESULT_PC4 = 2'b10
    } result_src_e;

    // Hazard FSM states
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    // Memory-wait watchdog saturation value; reaching it flags a timeout
    localparam logic [7:0] WD_LIMIT = 8'd255;

    // True when an enabled, non-x0 destination matches a source register
    function automatic logic reg_match(input logic       en,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs);
        return en && (rd != 5'd0) && (rs != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: memory-wait stall FSM, load-use / RAW stalls,
// branch flushes, operand forwarding, memory watchdog and stall counter.
// Build option: define HAZARD_FORWARDING_EN to enable operand forwarding;
// without it every RAW dependency in decode stalls until it drains.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  RS1_D,
    input  logic [4:0]  RS2_D,
    input  logic [4:0]  RS1_E,
    input  logic [4:0]  RS2_E,
    input  logic [4:0]  RD_E,
    input  logic [4:0]  RD_M,
    input  logic [4:0]  RD_W,
    input  logic        REG_W_En_E,
    input  logic        REG_W_En_M,
    input  logic        REG_W_En_W,
    input  logic [1:0]  Result_Src_Sel_E,
    input  logic        PC_Src_E,
    input  logic        MEM_Req_M,
    input  logic        MEM_Ready_M,
    output logic        Stall_F,
    output logic        Stall_D,
    output logic        Stall_E,
    output logic        Stall_M,
    output logic        Flush_D,
    output logic        Flush_E,
    output logic        Flush_W,
    output logic [1:0]  Forward_A_E,
    output logic [1:0]  Forward_B_E,
    output logic        Mem_Timeout,
    output logic [31:0] Stall_Cycles
);

    hz_state_e   state_q, state_d;
    logic [7:0]  wd_q, wd_d;
    logic        timeout_q, timeout_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic mem_wait_now;
    logic load_use;
    logic raw_stall;

    // The memory is stalling the pipeline right now (independent of state)
    assign mem_wait_now = MEM_Req_M && !MEM_Ready_M;

    // A load in execute feeds a source of the instruction in decode
    assign load_use = (Result_Src_Sel_E == RESULT_MEM) &&
                      (reg_match(REG_W_En_E, RD_E, RS1_D) ||
                       reg_match(REG_W_En_E, RD_E, RS2_D));

`ifdef HAZARD_FORWARDING_EN
    // Only loads need a stall; everything else is covered by forwarding
    assign raw_stall = load_use;

    // Operand forwarding; the younger M-stage result wins over W
    always_comb begin
        Forward_A_E = FWD_NONE;
        Forward_B_E = FWD_NONE;
        if (reg_match(REG_W_En_M, RD_M, RS1_E))      Forward_A_E = FWD_M;
        else if (reg_match(REG_W_En_W, RD_W, RS1_E)) Forward_A_E = FWD_W;
        if (reg_match(REG_W_En_M, RD_M, RS2_E))      Forward_B_E = FWD_M;
        else if (reg_match(REG_W_En_W, RD_W, RS2_E)) Forward_B_E = FWD_W;
    end
`else
    logic unused_fwd_srcs;

    // Without forwarding any in-flight writer of a decode source must drain
    assign raw_stall = load_use ||
                       reg_match(REG_W_En_E, RD_E, RS1_D) ||
                       reg_match(REG_W_En_E, RD_E, RS2_D) ||
                       reg_match(REG_W_En_M, RD_M, RS1_D) ||
                       reg_match(REG_W_En_M, RD_M, RS2_D) ||
                       reg_match(REG_W_En_W, RD_W, RS1_D) ||
                       reg_match(REG_W_En_W, RD_W, RS2_D);

    assign Forward_A_E     = FWD_NONE;
    assign Forward_B_E     = FWD_NONE;
    assign unused_fwd_srcs = ^{RS1_E, RS2_E};
`endif

    // Stall/flush priority: memory wait, then branch flush, then RAW stall
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        Stall_F = 1'b0;
        Stall_D = 1'b0;
        Stall_E = 1'b0;
        Stall_M = 1'b0;
        Flush_D = 1'b0;
        Flush_E = 1'b0;
        Flush_W = 1'b0;
        if (mem_wait_now) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Stall_M = 1'b1;
            Flush_W = 1'b1;
        end else if (PC_Src_E) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
        end else if (raw_stall) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Flush_E = 1'b1;
        end
    end

    // FSM next state: enter MEM_WAIT on a stalled request, leave on ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mem_wait_now) state_d = MEM_WAIT;
            MEM_WAIT: if (MEM_Ready_M)  state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Watchdog: restart on entry to MEM_WAIT, count while waiting, saturate
    always_comb begin
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if (state_q == RUN && state_d == MEM_WAIT) begin
            wd_d = 8'd0;
        end else if (state_q == MEM_WAIT && wd_q != WD_LIMIT) begin
            wd_d = wd_q + 8'd1;
        end
        if (wd_d == WD_LIMIT) timeout_d = 1'b1;
    end

    // Free-running count of fetch-stall cycles, wraps naturally
    assign stall_cnt_d = stall_cnt_q + {31'd0, Stall_F};

    // State registers; reset returns to RUN with cleared counters and flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= RUN;
            wd_q        <= 8'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q     <= state_d;
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Mem_Timeout  = timeout_q;
    assign Stall_Cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit. Expected combinational outputs are
// queued as each stimulus vector is applied and compared on the next
// falling edge; the stall counter is tracked by a bench-side count.
// Expectations adapt to HAZARD_FORWARDING_EN when it is defined.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    // Non-load RAW dependency: stall only when forwarding is absent
    localparam logic [3:0] RAW_ST = FWD_EN ? 4'b0000 : 4'b1100;
    localparam logic [2:0] RAW_FL = FWD_EN ? 3'b000  : 3'b010;
    localparam logic [1:0] EXP_M  = FWD_EN ? FWD_M   : FWD_NONE;
    localparam logic [1:0] EXP_W  = FWD_EN ? FWD_W   : FWD_NONE;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
    logic        REG_W_En_E, REG_W_En_M, REG_W_En_W;
    logic [1:0]  Result_Src_Sel_E;
    logic        PC_Src_E, MEM_Req_M, MEM_Ready_M;
    logic        Stall_F, Stall_D, Stall_E, Stall_M;
    logic        Flush_D, Flush_E, Flush_W;
    logic [1:0]  Forward_A_E, Forward_B_E;
    logic        Mem_Timeout;
    logic [31:0] Stall_Cycles;

    typedef struct {
        string       tag;
        logic [10:0] val;   // {stall F,D,E,M, flush D,E,W, fwd A, fwd B}
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt = 32'd0;

    hazard_unit dut (
        .CLK(CLK), .RST(RST),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
        .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
        .REG_W_En_E(REG_W_En_E), .REG_W_En_M(REG_W_En_M), .REG_W_En_W(REG_W_En_W),
        .Result_Src_Sel_E(Result_Src_Sel_E), .PC_Src_E(PC_Src_E),
        .MEM_Req_M(MEM_Req_M), .MEM_Ready_M(MEM_Ready_M),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_W(Flush_W),
        .Forward_A_E(Forward_A_E), .Forward_B_E(Forward_B_E),
        .Mem_Timeout(Mem_Timeout), .Stall_Cycles(Stall_Cycles)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: compare queued expectations away from the active edge
    always @(negedge CLK) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag,
                  {21'd0, Stall_F, Stall_D, Stall_E, Stall_M,
                   Flush_D, Flush_E, Flush_W, Forward_A_E, Forward_B_E},
                  {21'd0, e.val});
        end
    end

    task automatic idle();
        RS1_D = 5'd0; RS2_D = 5'd0; RS1_E = 5'd0; RS2_E = 5'd0;
        RD_E  = 5'd0; RD_M  = 5'd0; RD_W  = 5'd0;
        REG_W_En_E = 1'b0; REG_W_En_M = 1'b0; REG_W_En_W = 1'b0;
        Result_Src_Sel_E = RESULT_ALU;
        PC_Src_E = 1'b0; MEM_Req_M = 1'b0; MEM_Ready_M = 1'b1;
    endtask

    // Queue the expected outputs for the current inputs, then run one cycle
    task automatic step(input string tag, input logic [3:0] st, input logic [2:0] fl,
                        input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.tag = tag;
        e.val = {st, fl, fa, fb};
        sb_q.push_back(e);
        @(negedge CLK);
        @(posedge CLK);
        if (RST)        exp_cnt = 32'd0;
        else if (st[3]) exp_cnt = exp_cnt + 32'd1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        RST = 1'b1;
        idle();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_stall_cycles", Stall_Cycles, 32'd0);
        check("rst_timeout", {31'd0, Mem_Timeout}, 32'd0);
        step("rst_idle", 4'b0000, 3'b000, FWD_NONE, FWD_NONE);
        RST = 1'b0;
        step("idle", 4'b0000, 3'b000, FWD_NONE, FWD_NONE);

        // Load-use on RS1: one bubble, then clear
        RD_E = 5'd5; REG_W_En_E = 1'b1; Result_Src_Sel_E = RESULT_MEM; RS1_D = 5'd5;
        step("load_use_rs1", 4'b1100, 3'b010, FWD_NONE, FWD_NONE);
        idle();
        step("load_use_done", 4'b0000, 3'b000, FWD_NONE, FWD_NONE);
        check("cnt_load_use", Stall_Cycles, 32'd1);

        // x0 never matches
        RD_E = 5'd0; REG_W_En_E = 1'b1; Result_Src_Sel_E = RESULT_MEM;
        RD_M = 5'd0; REG_W_En_M = 1'b1; RD_W = 5'd0; REG_W_En_W = 1'b1;
        step("x0_no_match", 4'b0000, 3'b000, FWD_NONE, FWD_NONE);

        // Load-use on RS2, then the same with write disabled
        idle();
        RD_E = 5'd12; REG_W_En_E = 1'b1; Result_Src_Sel_E = RESULT_MEM;
        RS1_D = 5'd4; RS2_D = 5'd12;
        step("load_use_rs2", 4'b1100, 3'b010, FWD_NONE, FWD_NONE);
        REG_W_En_E = 1'b0;
        step("load_no_wen", 4'b0000, 3'b000, FWD_NONE, FWD_NONE);

        // ALU producer of x3 walking through E, M, W
        idle();
        RD_E = 5'd3; REG_W_En_E = 1'b1; RS1_D = 5'd3;
        step("raw_in_e", RAW_ST, RAW_FL, FWD_NONE, FWD_NONE);
        RD_E = 5'd0; REG_W_En_E = 1'b0; RD_M = 5'd3; REG_W_En_M = 1'b1;
        step("raw_in_m", RAW_ST, RAW_FL, FWD_NONE, FWD_NONE);
        RD_M = 5'd0; REG_W_En_M = 1'b0; RD_W = 5'd3; REG_W_En_W = 1'b1;
        step("raw_in_w", RAW_ST, RAW_FL, FWD_NONE, FWD_NONE);
        RD_W = 5'd0; REG_W_En_W = 1'b0;
        step("raw_drained", 4'b0000, 3'b000, FWD_NONE, FWD_NONE);
        idle();
        RD_W = 5'd9; RS2_D = 5'd9;
        step("raw_w_disabled", 4'b0000, 3'b000, FWD_NONE, FWD_NONE);

        // Forwarding selects
        idle();
        RD_M = 5'd7; RD_W = 5'd7; REG_W_En_M = 1'b1; REG_W_En_W = 1'b1; RS2_E = 5'd7;
        step("fwd_b_m", 4'b0000, 3'b000, FWD_NONE, EXP_M);
        RD_M = 5'd0;
        step("fwd_b_w", 4'b0000, 3'b000, FWD_NONE, EXP_W);
        RS2_E = 5'd0;
        step("fwd_b_x0", 4'b0000, 3'b000, FWD_NONE, FWD_NONE);
        RS1_E = 5'd7; RD_M = 5'd7;
        step("fwd_a_m", 4'b0000, 3'b000, EXP_M, FWD_NONE);
        REG_W_En_M = 1'b0;
        step("fwd_a_m_disabled", 4'b0000, 3'b000, EXP_W, FWD_NONE);

        // Branch overrides load-use
        idle();
        RD_E = 5'd5; REG_W_En_E = 1'b1; Result_Src_Sel_E = RESULT_MEM; RS1_D = 5'd5;
        PC_Src_E = 1'b1;
        step("branch_over_load", 4'b0000, 3'b110, FWD_NONE, FWD_NONE);

        // Branch held during a 3-cycle memory wait
        idle();
        PC_Src_E = 1'b1; MEM_Req_M = 1'b1; MEM_Ready_M = 1'b0;
        for (int i = 0; i < 3; i++)
            step("branch_in_wait", 4'b1111, 3'b001, FWD_NONE, FWD_NONE);
        MEM_Ready_M = 1'b1;
        step("branch_wait_end", 4'b0000, 3'b110, FWD_NONE, FWD_NONE);
        idle();
        step("after_branch", 4'b0000, 3'b000, FWD_NONE, FWD_NONE);
        check("cnt_after_wait", Stall_Cycles, exp_cnt);

        // Watchdog: 300-cycle wait, flag after 255 MEM_WAIT cycles, sticky
        idle();
        MEM_Req_M = 1'b1; MEM_Ready_M = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step("wd_wait", 4'b1111, 3'b001, FWD_NONE, FWD_NONE);
            if (i == 249) check("wd_not_yet", {31'd0, Mem_Timeout}, 32'd0);
        end
        check("wd_timeout", {31'd0, Mem_Timeout}, 32'd1);
        MEM_Ready_M = 1'b1;
        step("wd_ready", 4'b0000, 3'b000, FWD_NONE, FWD_NONE);
        idle();
        step("wd_idle", 4'b0000, 3'b000, FWD_NONE, FWD_NONE);
        check("wd_sticky", {31'd0, Mem_Timeout}, 32'd1);
        check("cnt_after_wd", Stall_Cycles, exp_cnt);

        // Reset in the middle of a memory wait
        MEM_Req_M = 1'b1; MEM_Ready_M = 1'b0;
        repeat (10) step("wait_pre_reset", 4'b1111, 3'b001, FWD_NONE, FWD_NONE);
        RST = 1'b1;
        #1;
        check("mid_rst_cnt", Stall_Cycles, 32'd0);
        check("mid_rst_timeout", {31'd0, Mem_Timeout}, 32'd0);
        step("wait_in_reset", 4'b1111, 3'b001, FWD_NONE, FWD_NONE);
        RST = 1'b0;
        MEM_Req_M = 1'b0;
        step("post_reset_idle", 4'b0000, 3'b000, FWD_NONE, FWD_NONE);
        check("post_rst_cnt", Stall_Cycles, 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
